// File: rtl/control_fsm_if.sv
// Memory handshake between the control FSM (master) and the memory port (slave).
interface control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/control_fsm.sv
// Instruction-sequencing control FSM: fetch, decode, execute/load/store with
// memory handshakes, timeout detection and a retired-instruction counter.
module control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    control_fsm_if.master        mem,
    input  logic                 run,
    input  logic [1:0]           instr_type,
    input  logic [7:0]           op,
    output logic                 ir_we,
    output logic                 pc_en,
    output logic                 reg_we,
    output logic                 wb_sel,
    output logic                 flags_we,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [15:0]          instr_count,
    output logic [2:0]           state
);
    localparam int                WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [7:0]        OP_CMP     = 8'h0B;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        LOAD    = 3'd4,
        LOAD_WB = 3'd5,
        STORE   = 3'd6,
        ERROR   = 3'd7
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [15:0]       count_reg, count_next;
    logic              illegal_reg, illegal_next;
    logic              bus_err_reg, bus_err_next;
    logic              in_mem_state;
    logic              timeout;
    logic              complete;

    assign in_mem_state = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == STORE);
    // An ack arriving on the limit cycle takes priority over the timeout.
    assign timeout      = in_mem_state && !mem.mem_ack && (wait_reg == WAIT_LIMIT);

    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        bus_err_next = bus_err_reg;
        complete     = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_en        = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        flags_we     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_we      = 1'b1;
                    pc_en      = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    bus_err_next = 1'b1;
                    state_next   = ERROR;
                end
            end
            DECODE: begin
                case (instr_type)
                    2'b00:   state_next = EXEC;
                    2'b01:   state_next = STORE;
                    2'b10:   state_next = LOAD;
                    default: begin
                        illegal_next = 1'b1;
                        state_next   = run ? FETCH : IDLE;
                    end
                endcase
            end
            EXEC: begin
                flags_we = 1'b1;
                reg_we   = (op != OP_CMP);
                complete = 1'b1;
            end
            LOAD: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                if (mem.mem_ack) begin
                    state_next = LOAD_WB;
                end else if (timeout) begin
                    bus_err_next = 1'b1;
                    state_next   = ERROR;
                end
            end
            LOAD_WB: begin
                reg_we   = 1'b1;
                wb_sel   = 1'b1;
                complete = 1'b1;
            end
            STORE: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b1;
                mem.addr_sel = 1'b1;
                if (mem.mem_ack) begin
                    complete = 1'b1;
                end else if (timeout) begin
                    bus_err_next = 1'b1;
                    state_next   = ERROR;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (complete) state_next = run ? FETCH : IDLE;
    end

    // Staying in a memory state implies no ack this cycle; any transition clears the count.
    assign wait_next  = (in_mem_state && (state_next == state_reg)) ? wait_reg + 1'b1 : '0;
    assign count_next = complete ? count_reg + 16'd1 : count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            wait_reg    <= '0;
            count_reg   <= 16'd0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            count_reg   <= count_next;
            illegal_reg <= illegal_next;
            bus_err_reg <= bus_err_next;
        end
    end

    assign illegal     = illegal_reg;
    assign bus_err     = bus_err_reg;
    assign instr_count = count_reg;
    assign state       = state_reg;
endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: table-driven cycle vectors plus
// hand-written timeout, counter-wrap and asynchronous-reset sequences.
module tb_control_fsm;
    localparam int TO = 15;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_LOAD = 3'd4, S_LWB = 3'd5, S_STORE = 3'd6, S_ERROR = 3'd7;

    // {mem_req, mem_we, addr_sel, ir_we, pc_en, reg_we, wb_sel, flags_we}
    localparam logic [7:0] B_NONE  = 8'h00;
    localparam logic [7:0] B_FETCH = 8'h80;
    localparam logic [7:0] B_FACK  = 8'h98;
    localparam logic [7:0] B_ADD   = 8'h05;
    localparam logic [7:0] B_CMP   = 8'h01;
    localparam logic [7:0] B_LOAD  = 8'hA0;
    localparam logic [7:0] B_LWB   = 8'h06;
    localparam logic [7:0] B_STORE = 8'hE0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [1:0]  instr_type = 2'b00;
    logic [7:0]  op = 8'h00;
    logic        ir_we, pc_en, reg_we, wb_sel, flags_we, illegal, bus_err;
    logic [15:0] instr_count;
    logic [2:0]  state;
    logic [7:0]  strobes;

    control_fsm_if mem_bus();

    control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem         (mem_bus),
        .run         (run),
        .instr_type  (instr_type),
        .op          (op),
        .ir_we       (ir_we),
        .pc_en       (pc_en),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .flags_we    (flags_we),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .instr_count (instr_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    assign strobes = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel,
                      ir_we, pc_en, reg_we, wb_sel, flags_we};

    typedef struct packed {
        logic        run;
        logic [1:0]  itype;
        logic [7:0]  op;
        logic        ack;
        logic [2:0]  st;
        logic [7:0]  strb;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [7:0]  strb;
        logic        ill;
        logic        berr;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[32];
    int   checks = 0;
    int   errors = 0;

    task automatic compare(input string name, input logic [2:0] st, input logic [7:0] strb,
                           input logic ill, input logic berr, input logic [15:0] cnt);
        logic [29:0] act, req;
        act = {state, strobes, illegal, bus_err, instr_count};
        req = {st, strb, ill, berr, cnt};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got state=%0d strb=%02h ill=%0b berr=%0b cnt=%04h, expected state=%0d strb=%02h ill=%0b berr=%0b cnt=%04h",
                     name, state, strobes, illegal, bus_err, instr_count, st, strb, ill, berr, cnt);
        end else begin
            $display("ok   %s: state=%0d strb=%02h ill=%0b berr=%0b cnt=%04h",
                     name, state, strobes, illegal, bus_err, instr_count);
        end
    endtask

    // Monitor: outputs are combinational from state, so sample mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            compare(mon_e.name, mon_e.st, mon_e.strb, mon_e.ill, mon_e.berr, mon_e.cnt);
        end
    end

    task automatic push_exp(input string name, input logic [2:0] st, input logic [7:0] strb,
                            input logic ill, input logic berr, input logic [15:0] cnt);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.strb = strb;
        e.ill  = ill;
        e.berr = berr;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic cyc(input string name, input logic r, input logic [1:0] it, input logic [7:0] o,
                       input logic a, input logic [2:0] st, input logic [7:0] strb,
                       input logic ill, input logic berr, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        run             = r;
        instr_type      = it;
        op              = o;
        mem_bus.mem_ack = a;
        push_exp(name, st, strb, ill, berr, cnt);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        reset_n         = 1'b0;
        run             = 1'b0;
        instr_type      = 2'b00;
        op              = 8'h00;
        mem_bus.mem_ack = 1'b0;
        push_exp(name, S_IDLE, B_NONE, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic vec_t v(input logic r, input logic [1:0] it, input logic [7:0] o, input logic a,
                               input logic [2:0] st, input logic [7:0] strb, input logic ill,
                               input logic [15:0] cnt);
        vec_t x;
        x.run = r; x.itype = it; x.op = o; x.ack = a;
        x.st = st; x.strb = strb; x.ill = ill; x.cnt = cnt;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ADD, CMP, LOAD (3 wait cycles), STORE, illegal, stray acks, run drop in LOAD
        vecs[0]  = v(0, 2'd0, 8'h05, 0, S_IDLE,   B_NONE,  0, 16'd0);
        vecs[1]  = v(1, 2'd0, 8'h05, 0, S_IDLE,   B_NONE,  0, 16'd0);
        vecs[2]  = v(1, 2'd0, 8'h05, 0, S_FETCH,  B_FETCH, 0, 16'd0);
        vecs[3]  = v(1, 2'd0, 8'h05, 1, S_FETCH,  B_FACK,  0, 16'd0);
        vecs[4]  = v(1, 2'd0, 8'h05, 0, S_DECODE, B_NONE,  0, 16'd0);
        vecs[5]  = v(1, 2'd0, 8'h05, 0, S_EXEC,   B_ADD,   0, 16'd0);
        vecs[6]  = v(1, 2'd0, 8'h0B, 1, S_FETCH,  B_FACK,  0, 16'd1);
        vecs[7]  = v(1, 2'd0, 8'h0B, 0, S_DECODE, B_NONE,  0, 16'd1);
        vecs[8]  = v(1, 2'd0, 8'h0B, 0, S_EXEC,   B_CMP,   0, 16'd1);
        vecs[9]  = v(1, 2'd2, 8'h00, 1, S_FETCH,  B_FACK,  0, 16'd2);
        vecs[10] = v(1, 2'd2, 8'h00, 0, S_DECODE, B_NONE,  0, 16'd2);
        vecs[11] = v(1, 2'd2, 8'h00, 0, S_LOAD,   B_LOAD,  0, 16'd2);
        vecs[12] = v(1, 2'd2, 8'h00, 0, S_LOAD,   B_LOAD,  0, 16'd2);
        vecs[13] = v(1, 2'd2, 8'h00, 0, S_LOAD,   B_LOAD,  0, 16'd2);
        vecs[14] = v(1, 2'd2, 8'h00, 1, S_LOAD,   B_LOAD,  0, 16'd2);
        vecs[15] = v(1, 2'd2, 8'h00, 0, S_LWB,    B_LWB,   0, 16'd2);
        vecs[16] = v(1, 2'd1, 8'h00, 1, S_FETCH,  B_FACK,  0, 16'd3);
        vecs[17] = v(1, 2'd1, 8'h00, 0, S_DECODE, B_NONE,  0, 16'd3);
        vecs[18] = v(1, 2'd1, 8'h00, 0, S_STORE,  B_STORE, 0, 16'd3);
        vecs[19] = v(1, 2'd1, 8'h00, 1, S_STORE,  B_STORE, 0, 16'd3);
        vecs[20] = v(1, 2'd3, 8'h00, 1, S_FETCH,  B_FACK,  0, 16'd4);
        vecs[21] = v(1, 2'd3, 8'h00, 0, S_DECODE, B_NONE,  0, 16'd4);
        vecs[22] = v(1, 2'd0, 8'h05, 0, S_FETCH,  B_FETCH, 1, 16'd4);
        vecs[23] = v(1, 2'd0, 8'h05, 1, S_FETCH,  B_FACK,  1, 16'd4);
        vecs[24] = v(1, 2'd0, 8'h05, 1, S_DECODE, B_NONE,  1, 16'd4);
        vecs[25] = v(1, 2'd0, 8'h05, 1, S_EXEC,   B_ADD,   1, 16'd4);
        vecs[26] = v(1, 2'd2, 8'h00, 1, S_FETCH,  B_FACK,  1, 16'd5);
        vecs[27] = v(1, 2'd2, 8'h00, 0, S_DECODE, B_NONE,  1, 16'd5);
        vecs[28] = v(0, 2'd2, 8'h00, 0, S_LOAD,   B_LOAD,  1, 16'd5);
        vecs[29] = v(0, 2'd2, 8'h00, 1, S_LOAD,   B_LOAD,  1, 16'd5);
        vecs[30] = v(0, 2'd2, 8'h00, 0, S_LWB,    B_LWB,   1, 16'd5);
        vecs[31] = v(0, 2'd0, 8'h00, 1, S_IDLE,   B_NONE,  1, 16'd6);

        mem_bus.mem_ack = 1'b0;
        do_reset("reset_initial");
        for (int i = 0; i < 32; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].run, vecs[i].itype, vecs[i].op, vecs[i].ack,
                vecs[i].st, vecs[i].strb, vecs[i].ill, 1'b0, vecs[i].cnt);
        end

        // Counter wrap: preload the retired count while idle, then retire one ADD.
        do_reset("reset_clears");
        @(posedge clk);
        #1;
        force dut.count_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.count_reg;
        cyc("wrap_idle",   0, 2'd0, 8'h05, 0, S_IDLE,   B_NONE,  0, 0, 16'hFFFF);
        cyc("wrap_start",  1, 2'd0, 8'h05, 0, S_IDLE,   B_NONE,  0, 0, 16'hFFFF);
        cyc("wrap_fetch",  1, 2'd0, 8'h05, 1, S_FETCH,  B_FACK,  0, 0, 16'hFFFF);
        cyc("wrap_decode", 1, 2'd0, 8'h05, 0, S_DECODE, B_NONE,  0, 0, 16'hFFFF);
        cyc("wrap_exec",   1, 2'd0, 8'h05, 0, S_EXEC,   B_ADD,   0, 0, 16'hFFFF);
        cyc("wrap_zero",   0, 2'd0, 8'h05, 0, S_FETCH,  B_FETCH, 0, 0, 16'h0000);

        // Ack on exactly the timeout cycle completes normally; a missing ack errors out.
        do_reset("reset_timeout");
        cyc("to_start", 1, 2'd0, 8'h05, 0, S_IDLE, B_NONE, 0, 0, 16'd0);
        for (int i = 0; i < TO; i++)
            cyc($sformatf("to_wait%0d", i), 1, 2'd0, 8'h05, 0, S_FETCH, B_FETCH, 0, 0, 16'd0);
        cyc("to_ack_edge", 1, 2'd0, 8'h05, 1, S_FETCH,  B_FACK, 0, 0, 16'd0);
        cyc("to_decode",   1, 2'd0, 8'h05, 0, S_DECODE, B_NONE, 0, 0, 16'd0);
        cyc("to_exec",     1, 2'd0, 8'h05, 0, S_EXEC,   B_ADD,  0, 0, 16'd0);
        for (int i = 0; i <= TO; i++)
            cyc($sformatf("to_hang%0d", i), 1, 2'd0, 8'h05, 0, S_FETCH, B_FETCH, 0, 0, 16'd1);
        cyc("err_run1", 1, 2'd0, 8'h05, 1, S_ERROR, B_NONE, 0, 1, 16'd1);
        cyc("err_run0", 0, 2'd0, 8'h05, 0, S_ERROR, B_NONE, 0, 1, 16'd1);
        cyc("err_hold", 1, 2'd1, 8'h05, 1, S_ERROR, B_NONE, 0, 1, 16'd1);

        // Asynchronous reset in the middle of a STORE wait.
        do_reset("reset_store");
        cyc("st_start",  1, 2'd1, 8'h00, 0, S_IDLE,   B_NONE,  0, 0, 16'd0);
        cyc("st_fetch",  1, 2'd1, 8'h00, 1, S_FETCH,  B_FACK,  0, 0, 16'd0);
        cyc("st_decode", 1, 2'd1, 8'h00, 0, S_DECODE, B_NONE,  0, 0, 16'd0);
        cyc("st_wait",   1, 2'd1, 8'h00, 0, S_STORE,  B_STORE, 0, 0, 16'd0);
        @(posedge clk);
        #1;
        compare("st_before_rst", S_STORE, B_STORE, 1'b0, 1'b0, 16'd0);
        #1;
        reset_n = 1'b0;
        #1;
        compare("st_async_rst", S_IDLE, B_NONE, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        compare("st_rst_held", S_IDLE, B_NONE, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;
        run     = 1'b0;
        cyc("st_after_rst", 0, 2'd0, 8'h00, 1, S_IDLE, B_NONE, 0, 0, 16'd0);

        @(posedge clk);
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max wait cycles for mem_ack in any memory state before bus error.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  1 = fetch/execute instructions; 0 = stop at next instruction boundary.
REQ-005 instr_type  input  2  decoder class: 00 R-type/ALU, 01 STORE, 10 LOAD, 11 or x illegal.
REQ-006 op  input  8  decoder ALU opcode; 8'h0B = CMP.
REQ-007 mem_ack  input  1  memory completion strobe for the current request.
REQ-008 mem_req  output  1  memory request, held until ack or timeout.
REQ-009 mem_we  output  1  1 = write request (STORE).
REQ-010 addr_sel  output  1  0 = PC addresses memory, 1 = register operand addresses memory.
REQ-011 ir_we  output  1  instruction register load strobe.
REQ-012 pc_en  output  1  PC increment strobe.
REQ-013 reg_we  output  1  register file write enable.
REQ-014 wb_sel  output  1  write-back source: 0 = ALU, 1 = memory data.
REQ-015 flags_we  output  1  ALU flag register write enable.
REQ-016 illegal  output  1  sticky; set when an illegal instr_type is decoded.
REQ-017 bus_err  output  1  sticky; set on memory timeout.
REQ-018 instr_count  output  16  retired-instruction counter.
REQ-019 state  output  3  current state encoding.

Function
REQ-020 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, LOAD=4, LOAD_WB=5, STORE=6, ERROR=7.
REQ-021 IDLE: all strobes 0; run=1 -> FETCH next cycle, else stay.
REQ-022 FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ack=1, ir_we=1 and pc_en=1 in that same cycle, next DECODE.
REQ-023 DECODE: one cycle, no strobes; next state from instr_type: 00 -> EXEC, 01 -> STORE, 10 -> LOAD, 11/x -> set illegal, then FETCH if run else IDLE.
REQ-024 EXEC: one cycle; flags_we=1; reg_we=1, wb_sel=0, except reg_we=0 when op=8'h0B (CMP).
REQ-025 LOAD: mem_req=1, addr_sel=1, mem_we=0; on mem_ack -> LOAD_WB.
REQ-026 LOAD_WB: one cycle; reg_we=1, wb_sel=1, flags_we=0.
REQ-027 STORE: mem_req=1, mem_we=1, addr_sel=1; reg_we=0; on mem_ack -> instruction complete.
REQ-028 Completion points are EXEC, LOAD_WB and the STORE ack cycle; at each, next state is FETCH if run=1, else IDLE.
REQ-029 run=0 mid-instruction SHALL NOT abort it; the instruction completes, then IDLE.
REQ-030 instr_count SHALL increment by 1 at each completion point; illegal skips do not count; wraps 16'hFFFF -> 0.
REQ-031 Wait counter SHALL clear on entry to FETCH, LOAD and STORE and increment each cycle the state is held with mem_ack=0.
REQ-032 In a memory state with mem_ack=0 and wait counter = MEM_TIMEOUT, bus_err SHALL set and the next state SHALL be ERROR; mem_ack=1 in that cycle wins (normal completion).
REQ-033 ERROR: all strobes 0; held until reset, regardless of run.
REQ-034 mem_ack outside FETCH/LOAD/STORE SHALL be ignored.
REQ-035 Strobes SHALL be decoded combinationally from current state, op and mem_ack only; no strobe is asserted in two consecutive instructions by stale state.

Reset
REQ-036 reset_n=0 SHALL immediately force state=IDLE, all strobes 0, illegal=0, bus_err=0, instr_count=0, wait counter=0, including mid-memory-access.
REQ-037 After reset_n rises, first transition occurs on the first rising clk edge with run=1.

Verification
REQ-038 run=1, R-type ADD (instr_type=00, op=8'h05), mem_ack one cycle after req -> states 0,1,1,2,3,1; reg_we=1 and flags_we=1 in EXEC; instr_count=1.
REQ-039 CMP (op=8'h0B) -> EXEC shows flags_we=1, reg_we=0.
REQ-040 LOAD with mem_ack delayed 3 cycles -> LOAD held 4 cycles, addr_sel=1, then LOAD_WB with reg_we=1, wb_sel=1; STORE -> mem_we=1 until ack, reg_we never 1.
REQ-041 instr_type=11 -> illegal=1 after DECODE, returns to FETCH, instr_count unchanged; instr_count at 16'hFFFF + one ADD -> 0.
REQ-042 mem_ack held 0 in FETCH -> ERROR after MEM_TIMEOUT+1 cycles, bus_err=1; mem_ack=1 on exactly the timeout cycle -> normal DECODE, bus_err=0.
REQ-043 run dropped during LOAD -> LOAD_WB completes, then IDLE; reset_n pulsed low during STORE -> immediate IDLE, all outputs 0.
